vedic_seq_mul32: RTL and testbench



---
 rtl/vedic_seq_mul32.sv | 65 ++++++
 tb/tb_vedic_seq_mul32.sv | 135 +++++++++++++
 2 files changed

// File: rtl/vedic_seq_mul32.sv
// vedic_seq_mul32: sequential 32x32 unsigned multiplier, one 16x16 partial product per cycle
module vedic_seq_mul32 (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [63:0] p,
    output logic        busy
);
    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;
    state_t      state, state_nxt;
    logic [1:0]  step;
    logic [31:0] a_r, b_r;
    logic [15:0] x, y;
    logic [31:0] pp;
    logic [63:0] acc, term, sum;
    logic        accept;
    // pick operand halves for the current step, form the product and align it
    always_comb begin
        x    = step[0] ? a_r[31:16] : a_r[15:0];
        y    = step[1] ? b_r[31:16] : b_r[15:0];
        pp   = 32'(x) * 32'(y);
        term = (step == 2'd0) ? {32'd0, pp} : (step == 2'd3) ? {pp, 32'd0} : {16'd0, pp, 16'd0};
        sum  = acc + term;
    end
    // next state and handshake outputs decoded from the registered state only
    always_comb begin
        accept    = (state == IDLE) && in_valid;
        state_nxt = accept ? CALC
                  : (state == CALC && step == 2'd3) ? DONE
                  : (state == DONE && out_ready) ? IDLE
                  : state;
        in_ready  = (state == IDLE);
        out_valid = (state == DONE);
        busy      = (state != IDLE);
    end
    // state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end
    // operand capture, accumulation and product latch on the final step
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_r  <= '0;
            b_r  <= '0;
            acc  <= '0;
            step <= '0;
            p    <= '0;
        end else if (accept) begin
            a_r  <= a;
            b_r  <= b;
            acc  <= '0;
            step <= '0;
        end else if (state == CALC) begin
            acc  <= sum;
            step <= step + 2'd1;
            if (step == 2'd3) p <= sum;
        end
    end
endmodule

// File: tb/tb_vedic_seq_mul32.sv
// tb_vedic_seq_mul32: randomized self-checking bench for the sequential multiplier
module tb_vedic_seq_mul32;
    logic        clk = 0;
    logic        rst_n = 0;
    logic        in_valid = 0;
    logic        in_ready;
    logic [31:0] a = 0;
    logic [31:0] b = 0;
    logic        out_valid;
    logic        out_ready = 0;
    logic [63:0] p;
    logic        busy;
    int          n_tests = 0;
    int          n_fail = 0;

    vedic_seq_mul32 dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .out_valid(out_valid), .out_ready(out_ready), .p(p), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%016h expected 0x%016h", tag, got, exp);
        end
    endtask

    function automatic logic [63:0] ref_mul(input logic [31:0] x, input logic [31:0] y);
        return 64'(x) * 64'(y);
    endfunction

    // one full transaction; noisy=1 scribbles on a/b with in_valid high during CALC
    task automatic txn(input logic [31:0] x, input logic [31:0] y, input int hold, input bit noisy);
        logic [63:0] exp;
        exp = ref_mul(x, y);
        @(negedge clk);
        a = x;
        b = y;
        in_valid = 1;
        check("in_ready_idle", 64'(in_ready), 64'd1);
        @(posedge clk);
        #1;
        if (noisy) begin
            a = $urandom;
            b = $urandom;
        end else in_valid = 0;
        check("calc_in_ready", 64'(in_ready), 64'd0);
        check("calc_busy", 64'(busy), 64'd1);
        check("calc_out_valid", 64'(out_valid), 64'd0);
        repeat (3) begin
            @(posedge clk);
            #1;
            if (noisy) begin
                a = $urandom;
                b = $urandom;
            end
            check("calc_out_valid", 64'(out_valid), 64'd0);
        end
        @(posedge clk);
        #1;
        check("latency_out_valid", 64'(out_valid), 64'd1);
        check("product", p, exp);
        repeat (hold) begin
            @(posedge clk);
            #1;
            check("hold_out_valid", 64'(out_valid), 64'd1);
            check("hold_p", p, exp);
            check("hold_in_ready", 64'(in_ready), 64'd0);
        end
        in_valid = 0;
        out_ready = 1;
        @(posedge clk);
        #1;
        out_ready = 0;
        check("release_out_valid", 64'(out_valid), 64'd0);
        check("release_in_ready", 64'(in_ready), 64'd1);
        check("release_busy", 64'(busy), 64'd0);
        check("idle_p_held", p, exp);
    endtask

    initial begin
        #2;
        check("rst_in_ready", 64'(in_ready), 64'd1);
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_p", p, 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        @(negedge clk);
        rst_n = 1;

        txn(32'h0000FFFF, 32'h0000FFFF, 0, 0);
        check("carry_const", p, 64'h00000000FFFE0001);
        txn(32'hFFFFFFFF, 32'hFFFFFFFF, 0, 0);
        check("full_scale_const", p, 64'hFFFFFFFE00000001);
        txn(32'h80000000, 32'h00000002, 10, 0);
        txn(32'h00010000, 32'h00010000, 0, 1);
        check("isolation_const", p, 64'h0000000100000000);
        txn(32'h0, 32'hDEADBEEF, 0, 0);
        txn(32'h12345678, 32'h0, 1, 0);

        // reset mid-operation: accept 3*5, drop rst_n after step1
        @(negedge clk);
        a = 3;
        b = 5;
        in_valid = 1;
        @(posedge clk);
        #1;
        in_valid = 0;
        repeat (2) @(posedge clk);
        #2;
        rst_n = 0;
        #1;
        check("midrst_in_ready", 64'(in_ready), 64'd1);
        check("midrst_out_valid", 64'(out_valid), 64'd0);
        check("midrst_p", p, 64'd0);
        check("midrst_busy", 64'(busy), 64'd0);
        repeat (6) begin
            @(posedge clk);
            #1;
            check("midrst_no_valid", 64'(out_valid), 64'd0);
        end
        @(negedge clk);
        rst_n = 1;
        txn(32'd3, 32'd5, 0, 0);
        check("after_rst_const", p, 64'h000000000000000F);

        for (int i = 0; i < 25; i++)
            txn($urandom, $urandom, int'($urandom_range(0, 3)), bit'($urandom_range(0, 1)));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
